unified_mem_arbiter: RTL and testbench

Arbitrates one single-ported, fixed-latency unified memory between the instruction-fetch port (IF) and the data-access port (MEM stage) of the 5-stage MIPS pipeline.
Runs a grant/access/response FSM with round-robin tie-breaking.
Returns read data and a one-cycle ack to the winning requester.
Exports per-port stall flags that the pipeline controller uses to freeze stages.

---
 rtl/unified_mem_arbiter.sv | 110 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - round-robin arbiter sharing one fixed-latency memory between IF and data ports
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state;
    logic       last_grant_d;
    logic       owner_d;
    logic [3:0] wait_cnt;
    logic       grant_any;
    logic       grant_d;

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant_any = if_req | d_req;
        grant_d   = d_req & (~if_req | ~last_grant_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            owner_d      <= 1'b0;
            wait_cnt     <= '0;
            mem_cs       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_ack       <= 1'b0;
            d_ack        <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_d      <= grant_d;
                        last_grant_d <= grant_d;
                        mem_cs       <= 1'b1;
                        if (grant_d) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_we    <= d_wen;
                        end else begin
                            mem_addr <= if_addr;
                            mem_we   <= 1'b0;
                        end
                        wait_cnt <= 4'(WAIT_CYCLES - 1);
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_we still holds the latched direction of this access.
                    if (wait_cnt == 4'd0) begin
                        mem_cs <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner_d) begin
                            d_ack <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - table, directed and model-checked random tests for unified_mem_arbiter
module tb_unified_mem_arbiter;

    localparam int W = 2;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z    = 32'h0;
    localparam logic [31:0] A_IF = 32'h10;
    localparam logic [31:0] A_D  = 32'h100;
    localparam logic [31:0] A_W  = 32'h200;
    localparam logic [31:0] RI   = 32'h20080005;
    localparam logic [31:0] RD   = 32'hCAFEF00D;
    localparam logic [31:0] WD   = 32'hDEADBEEF;

    logic clk;
    logic rst;
    logic if_req, if_ack, d_req, d_wen, d_ack, mem_cs, mem_we, stall_if, stall_mem, busy;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic u1_if_req, u1_if_ack, u1_d_req, u1_d_wen, u1_d_ack, u1_mem_cs, u1_mem_we;
    logic u1_stall_if, u1_stall_mem, u1_busy;
    logic [31:0] u1_if_addr, u1_if_rdata, u1_d_addr, u1_d_wdata, u1_d_rdata;
    logic [31:0] u1_mem_addr, u1_mem_wdata, u1_mem_rdata;
    logic [31:0] mem [256];

    int n_cmp = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata    = mem[mem_addr[9:2]];
    assign u1_mem_rdata = mem[u1_mem_addr[9:2]];

    unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(u1_if_req), .if_addr(u1_if_addr), .if_rdata(u1_if_rdata), .if_ack(u1_if_ack),
        .d_req(u1_d_req), .d_wen(u1_d_wen), .d_addr(u1_d_addr), .d_wdata(u1_d_wdata),
        .d_rdata(u1_d_rdata), .d_ack(u1_d_ack),
        .mem_cs(u1_mem_cs), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
        .mem_rdata(u1_mem_rdata), .stall_if(u1_stall_if), .stall_mem(u1_stall_mem), .busy(u1_busy)
    );

    typedef struct {
        logic rst, ifr;
        logic [31:0] ifa;
        logic dr, dw;
        logic [31:0] da, dwd;
        logic cs, we;
        logic [31:0] ma, mwd;
        logic iack, dack;
        logic [31:0] ird, drd;
        logic sif, smem, bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk1(input string nm, input logic a, input logic e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0b expected %0b", nm, $time, a, e);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
        end
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
        u1_if_req = 0; u1_if_addr = 0; u1_d_req = 0; u1_d_wen = 0; u1_d_addr = 0; u1_d_wdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    function automatic logic [31:0] raddr();
        return {22'b0, 8'($urandom), 2'b0};
    endfunction

    bit act, resp, iack_e, dack_e, tv, t_d, t_wen, lg_d;
    logic [31:0] t_addr, t_wdata, e_ird, e_drd;
    int t_g, free_at;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[4]  = RI;
        mem[64] = RD;

        // rst ifr ifa dr dw da dwd | cs we ma mwd iack dack ird drd sif smem bsy
        vecs.push_back('{H, L, Z,    L, L, Z,   Z,  L, L, Z,    Z,  L, L, Z,  Z,  L, L, L});
        vecs.push_back('{L, H, A_IF, L, L, Z,   Z,  L, L, Z,    Z,  L, L, Z,  Z,  H, L, L});
        vecs.push_back('{L, H, A_IF, L, L, Z,   Z,  H, L, A_IF, Z,  L, L, Z,  Z,  H, L, H});
        vecs.push_back('{L, H, A_IF, L, L, Z,   Z,  H, L, A_IF, Z,  L, L, Z,  Z,  H, L, H});
        vecs.push_back('{L, H, A_IF, L, L, Z,   Z,  L, L, A_IF, Z,  H, L, RI, Z,  L, L, H});
        vecs.push_back('{L, L, Z,    L, L, Z,   Z,  L, L, A_IF, Z,  L, L, RI, Z,  L, L, L});
        vecs.push_back('{H, L, Z,    L, L, Z,   Z,  L, L, A_IF, Z,  L, L, RI, Z,  L, L, L});
        vecs.push_back('{L, H, A_IF, H, L, A_D, Z,  L, L, Z,    Z,  L, L, Z,  Z,  H, H, L});
        vecs.push_back('{L, H, A_IF, H, L, A_D, Z,  H, L, A_D,  Z,  L, L, Z,  Z,  H, H, H});
        vecs.push_back('{L, H, A_IF, H, L, A_D, Z,  H, L, A_D,  Z,  L, L, Z,  Z,  H, H, H});
        vecs.push_back('{L, H, A_IF, L, L, Z,   Z,  L, L, A_D,  Z,  L, H, Z,  RD, H, L, H});
        vecs.push_back('{L, H, A_IF, L, L, Z,   Z,  L, L, A_D,  Z,  L, L, Z,  RD, H, L, L});
        vecs.push_back('{L, H, A_IF, L, L, Z,   Z,  H, L, A_IF, Z,  L, L, Z,  RD, H, L, H});
        vecs.push_back('{L, H, A_IF, L, L, Z,   Z,  H, L, A_IF, Z,  L, L, Z,  RD, H, L, H});
        vecs.push_back('{L, L, Z,    L, L, Z,   Z,  L, L, A_IF, Z,  H, L, RI, RD, L, L, H});
        vecs.push_back('{L, L, Z,    L, L, Z,   Z,  L, L, A_IF, Z,  L, L, RI, RD, L, L, L});
        vecs.push_back('{H, L, Z,    L, L, Z,   Z,  L, L, A_IF, Z,  L, L, RI, RD, L, L, L});
        vecs.push_back('{L, L, Z,    H, H, A_W, WD, L, L, Z,    Z,  L, L, Z,  Z,  L, H, L});
        vecs.push_back('{L, L, Z,    H, H, A_W, WD, H, H, A_W,  WD, L, L, Z,  Z,  L, H, H});
        vecs.push_back('{L, L, Z,    H, H, A_W, WD, H, H, A_W,  WD, L, L, Z,  Z,  L, H, H});
        vecs.push_back('{L, L, Z,    L, L, Z,   Z,  L, L, A_W,  WD, L, H, Z,  Z,  L, L, H});
        vecs.push_back('{L, L, Z,    L, L, Z,   Z,  L, L, A_W,  WD, L, L, Z,  Z,  L, L, L});

        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
            d_req = vecs[i].dr; d_wen = vecs[i].dw; d_addr = vecs[i].da; d_wdata = vecs[i].dwd;
            #1;
            chk1("vec mem_cs", mem_cs, vecs[i].cs);
            chk1("vec mem_we", mem_we, vecs[i].we);
            chk32("vec mem_addr", mem_addr, vecs[i].ma);
            chk32("vec mem_wdata", mem_wdata, vecs[i].mwd);
            chk1("vec if_ack", if_ack, vecs[i].iack);
            chk1("vec d_ack", d_ack, vecs[i].dack);
            chk32("vec if_rdata", if_rdata, vecs[i].ird);
            chk32("vec d_rdata", d_rdata, vecs[i].drd);
            chk1("vec stall_if", stall_if, vecs[i].sif);
            chk1("vec stall_mem", stall_mem, vecs[i].smem);
            chk1("vec busy", busy, vecs[i].bsy);
            @(negedge clk);
        end

        // Both ports requesting continuously: strict D,I alternation, acks 4 cycles apart.
        do_reset();
        if_req = 1; if_addr = A_IF; d_req = 1; d_addr = A_D;
        for (int c = 0; c < 34; c++) begin
            bit slot;
            int k;
            #1;
            slot = (c >= 3) && ((c - 3) % 4 == 0) && ((c - 3) / 4 < 8);
            k = (c - 3) / 4;
            chk1("rr d_ack", d_ack, slot && (k % 2 == 0));
            chk1("rr if_ack", if_ack, slot && (k % 2 == 1));
            chk1("rr ack_excl", if_ack & d_ack, 1'b0);
            @(negedge clk);
        end

        // Reset in the middle of an access aborts it silently.
        do_reset();
        if_req = 1; if_addr = A_IF;
        #1; chk1("abort c0 busy", busy, 1'b0);
        @(negedge clk); #1; chk1("abort c1 mem_cs", mem_cs, 1'b1);
        @(negedge clk); rst = 1; #1; chk1("abort c2 mem_cs", mem_cs, 1'b1);
        @(negedge clk); rst = 0; #1;
        chk1("abort c3 mem_cs", mem_cs, 1'b0);
        chk1("abort c3 busy", busy, 1'b0);
        chk1("abort c3 if_ack", if_ack, 1'b0);
        chk32("abort c3 if_rdata", if_rdata, Z);
        for (int c = 4; c < 8; c++) begin
            @(negedge clk); #1;
            chk1("abort retry if_ack", if_ack, c == 6);
            chk1("abort retry mem_cs", mem_cs, c == 4 || c == 5);
            chk32("abort retry if_rdata", if_rdata, (c >= 6) ? RI : Z);
            if (c == 6) if_req = 0;
        end

        // Single-cycle access on the WAIT_CYCLES=1 instance.
        do_reset();
        u1_d_req = 1; u1_d_addr = A_D;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk1("w1 mem_cs", u1_mem_cs, c == 1);
            chk1("w1 d_ack", u1_d_ack, c == 2);
            chk1("w1 busy", u1_busy, c == 1 || c == 2);
            chk32("w1 d_rdata", u1_d_rdata, (c >= 2) ? RD : Z);
            chk1("w1 mem_we", u1_mem_we, 1'b0);
            chk1("w1 stall_mem", u1_stall_mem, c < 2);
            chk1("w1 if_ack", u1_if_ack | u1_stall_if, 1'b0);
            chk32("w1 if_rdata", u1_if_rdata | u1_mem_wdata, Z);
            if (c == 1) chk32("w1 mem_addr", u1_mem_addr, A_D);
            if (c == 2) u1_d_req = 0;
            @(negedge clk);
        end

        // Random traffic against a transaction-timeline reference model.
        do_reset();
        tv = 0; free_at = 0; lg_d = 0; e_ird = 0; e_drd = 0;
        t_d = 0; t_wen = 0; t_addr = 0; t_wdata = 0; t_g = 0;
        for (int c = 0; c < 1500; c++) begin
            act    = tv && (c >= t_g + 1) && (c <= t_g + W);
            resp   = tv && (c == t_g + W + 1);
            iack_e = resp && !t_d;
            dack_e = resp && t_d;
            if (if_req && iack_e) begin
                if_req = 1'($urandom_range(0, 1)); if_addr = raddr();
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = raddr();
            end
            if (d_req && dack_e) begin
                d_req = 1'($urandom_range(0, 1)); d_addr = raddr();
                d_wen = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_addr = raddr(); d_wen = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end
            if (resp && !t_wen) begin
                if (t_d) e_drd = mem[t_addr[9:2]];
                else     e_ird = mem[t_addr[9:2]];
            end
            #1;
            chk1("rnd mem_cs", mem_cs, act);
            chk1("rnd busy", busy, act || resp);
            chk1("rnd if_ack", if_ack, iack_e);
            chk1("rnd d_ack", d_ack, dack_e);
            chk32("rnd if_rdata", if_rdata, e_ird);
            chk32("rnd d_rdata", d_rdata, e_drd);
            chk1("rnd stall_if", stall_if, if_req && !iack_e);
            chk1("rnd stall_mem", stall_mem, d_req && !dack_e);
            chk1("rnd mem_we", mem_we, act && t_wen);
            if (act) chk32("rnd mem_addr", mem_addr, t_addr);
            if (act && t_wen) chk32("rnd mem_wdata", mem_wdata, t_wdata);
            if (c >= free_at && (if_req || d_req)) begin
                tv      = 1;
                t_d     = d_req && (!if_req || !lg_d);
                t_addr  = t_d ? d_addr : if_addr;
                t_wen   = t_d && d_wen;
                t_wdata = d_wdata;
                t_g     = c;
                free_at = c + W + 2;
                lg_d    = t_d;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
